// File: rtl/store_monitor.sv
// Store monitor: holds a table of expected (address, data) CPU stores and checks
// that the observed store stream matches it in order, within a cycle budget.
module store_monitor #(
  parameter int DEPTH     = 8,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 1000,
  parameter int EDGE_MODE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  input  logic [DW-1:0]            ld_data,
  output logic                     ld_ready,
  input  logic                     start,
  input  logic                     clear,
  input  logic                     memwrite,
  input  logic [AW-1:0]            dataaddr,
  input  logic [DW-1:0]            writedata,
  output logic                     done,
  output logic                     pass,
  output logic [2:0]               fail_code,
  output logic [$clog2(DEPTH):0]   fail_index,
  output logic [$clog2(DEPTH):0]   match_count,
  output logic [31:0]              cycle_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TN = 1 << IW;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   match_count_q, match_count_d;
  logic [31:0]     cycle_count_q, cycle_count_d;
  logic [2:0]      fail_code_q, fail_code_d;
  logic [CW-1:0]   fail_index_q, fail_index_d;
  logic            mw_prev_q, mw_prev_d;

  logic [AW-1:0]   tbl_addr_q [TN];
  logic [DW-1:0]   tbl_data_q [TN];
  logic            tbl_we;
  logic            store_ev;
  logic [AW-1:0]   exp_addr;
  logic [DW-1:0]   exp_data;

  assign store_ev = (EDGE_MODE != 0) ? (memwrite && !mw_prev_q) : memwrite;
  assign exp_addr = tbl_addr_q[idx_q[IW-1:0]];
  assign exp_data = tbl_data_q[idx_q[IW-1:0]];

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    idx_d         = idx_q;
    match_count_d = match_count_q;
    cycle_count_d = cycle_count_q;
    fail_code_d   = fail_code_q;
    fail_index_d  = fail_index_q;
    mw_prev_d     = memwrite;
    tbl_we        = 1'b0;
    ld_ready      = 1'b0;

    case (state_q)
      S_IDLE: begin
        ld_ready = (count_q < DEPTH_C);
        if (ld_valid && ld_ready) begin
          tbl_we  = 1'b1;
          count_d = count_q + CW'(1);
        end
        if (start && ((count_q != '0) || tbl_we)) begin
          state_d       = S_RUN;
          idx_d         = '0;
          match_count_d = '0;
          cycle_count_d = '0;
        end
      end
      S_RUN: begin
        if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 32'd1;
        if (store_ev) begin
          if (dataaddr != exp_addr) begin
            state_d      = S_FAIL;
            fail_code_d  = 3'd1;
            fail_index_d = idx_q;
          end else if (writedata != exp_data) begin
            state_d      = S_FAIL;
            fail_code_d  = 3'd2;
            fail_index_d = idx_q;
          end else begin
            match_count_d = match_count_q + CW'(1);
            idx_d         = idx_q + CW'(1);
            if (idx_q == count_q - CW'(1)) state_d = S_PASS;
          end
        end
        // Timeout only fires if this cycle neither completed nor mismatched.
        if ((state_d == S_RUN) && (cycle_count_q == TO_LAST)) begin
          state_d      = S_FAIL;
          fail_code_d  = 3'd3;
          fail_index_d = idx_d;
        end
        // The count only advances for cycles that are followed by more RUN.
        if (state_d != S_RUN) cycle_count_d = cycle_count_q;
      end
      S_PASS: begin
        if (store_ev && !clear) begin
          state_d      = S_FAIL;
          fail_code_d  = 3'd4;
          fail_index_d = count_q;
        end
      end
      S_FAIL: ;
      default: state_d = S_IDLE;
    endcase

    if (clear && ((state_q == S_PASS) || (state_q == S_FAIL))) begin
      state_d       = S_IDLE;
      count_d       = '0;
      idx_d         = '0;
      match_count_d = '0;
      cycle_count_d = '0;
      fail_code_d   = '0;
      fail_index_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      idx_q         <= '0;
      match_count_q <= '0;
      cycle_count_q <= '0;
      fail_code_q   <= '0;
      fail_index_q  <= '0;
      mw_prev_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      match_count_q <= match_count_d;
      cycle_count_q <= cycle_count_d;
      fail_code_q   <= fail_code_d;
      fail_index_q  <= fail_index_d;
      mw_prev_q     <= mw_prev_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && tbl_we) begin
      tbl_addr_q[count_q[IW-1:0]] <= ld_addr;
      tbl_data_q[count_q[IW-1:0]] <= ld_data;
    end
  end

  assign done        = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass        = (state_q == S_PASS);
  assign fail_code   = fail_code_q;
  assign fail_index  = fail_index_q;
  assign match_count = match_count_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_store_monitor.sv
// Bench for store_monitor: an edge-mode and a level-mode instance see the same
// store stream; final outcomes are predicted from the store plan and scoreboarded.
module tb_store_monitor;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        reset, ld_valid, start, clear, memwrite;
  logic [15:0] ld_addr, ld_data, dataaddr, writedata;

  logic        ld_ready_e, done_e, pass_e, ld_ready_l, done_l, pass_l;
  logic [2:0]  fail_code_e, fail_index_e, match_count_e;
  logic [2:0]  fail_code_l, fail_index_l, match_count_l;
  logic [31:0] cycle_count_e, cycle_count_l;

  always #5 clk = ~clk;

  store_monitor #(.DEPTH(DEPTH), .AW(16), .DW(16), .TIMEOUT(TIMEOUT), .EDGE_MODE(1)) u_dut_e (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready_e), .start(start), .clear(clear), .memwrite(memwrite),
    .dataaddr(dataaddr), .writedata(writedata), .done(done_e), .pass(pass_e),
    .fail_code(fail_code_e), .fail_index(fail_index_e), .match_count(match_count_e),
    .cycle_count(cycle_count_e));

  store_monitor #(.DEPTH(DEPTH), .AW(16), .DW(16), .TIMEOUT(TIMEOUT), .EDGE_MODE(0)) u_dut_l (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready_l), .start(start), .clear(clear), .memwrite(memwrite),
    .dataaddr(dataaddr), .writedata(writedata), .done(done_l), .pass(pass_l),
    .fail_code(fail_code_l), .fail_index(fail_index_l), .match_count(match_count_l),
    .cycle_count(cycle_count_l));

  typedef struct packed {
    logic        pass;
    logic [2:0]  code;
    logic [2:0]  fi;
    logic [2:0]  mc;
    logic [31:0] cc;
  } res_t;

  res_t q_e[$];
  res_t q_l[$];
  int vectors = 0;
  int miscompares = 0;

  logic [15:0] ea[DEPTH];
  logic [15:0] ed[DEPTH];
  int          n;
  logic        pmw[64];
  logic [15:0] pa[64];
  logic [15:0] pd[64];
  int          plen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Replays the planned store stream against the entry list, one RUN cycle at a time.
  function automatic res_t model(input bit edge_mode);
    res_t r;
    int   st;
    int   idx;
    logic cur, prv, ev;
    r = '0;
    st = 0;
    idx = 0;
    for (int t = 0; t < plen + TIMEOUT + 1; t++) begin
      cur = (t < plen) ? pmw[t] : 1'b0;
      prv = (t > 0 && t - 1 < plen) ? pmw[t-1] : 1'b0;
      ev  = edge_mode ? (cur && !prv) : cur;
      if (st == 0) begin
        if (ev) begin
          if (pa[t] != ea[idx]) begin
            st = 2; r.code = 3'd1; r.fi = 3'(idx); r.mc = 3'(idx); r.cc = 32'(t);
          end else if (pd[t] != ed[idx]) begin
            st = 2; r.code = 3'd2; r.fi = 3'(idx); r.mc = 3'(idx); r.cc = 32'(t);
          end else begin
            idx++;
            if (idx == n) begin
              st = 1; r.pass = 1'b1; r.mc = 3'(n); r.cc = 32'(t);
            end
          end
        end
        if (st == 0 && t == TIMEOUT - 1) begin
          st = 2; r.code = 3'd3; r.fi = 3'(idx); r.mc = 3'(idx); r.cc = 32'(t);
        end
      end else if (st == 1) begin
        if (ev) begin
          st = 2; r.pass = 1'b0; r.code = 3'd4; r.fi = 3'(n);
        end
      end
    end
    return r;
  endfunction

  task automatic plan_clear(input int len);
    plen = len;
    for (int t = 0; t < 64; t++) begin
      pmw[t] = 1'b0; pa[t] = '0; pd[t] = '0;
    end
  endtask

  task automatic plan_store(input int t0, input int len, input logic [15:0] a, input logic [15:0] d);
    for (int t = t0; t < t0 + len; t++) begin
      pmw[t] = 1'b1; pa[t] = a; pd[t] = d;
    end
  endtask

  task automatic run_scn(input bit overflow, input bit together);
    int w;
    q_e.push_back(model(1'b1));
    q_l.push_back(model(1'b0));
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1; ld_addr = ea[i]; ld_data = ed[i];
      chk("ld_ready_load", ld_ready_e, 1);
      if (together && i == n - 1) start = 1'b1;
      tick();
    end
    if (overflow && !together && n == DEPTH) begin
      ld_valid = 1'b1; ld_addr = ~ea[0]; ld_data = ~ed[0];
      chk("ld_ready_full", ld_ready_e, 0);
      tick();
    end
    ld_valid = 1'b0;
    if (!together) begin
      start = 1'b1;
      tick();
    end
    start = 1'b0;
    for (int t = 0; t < plen; t++) begin
      memwrite = pmw[t]; dataaddr = pa[t]; writedata = pd[t];
      tick();
    end
    memwrite = 1'b0;
    w = 0;
    while (!(done_e && done_l) && w < 60) begin
      tick();
      w++;
    end
    if (!(done_e && done_l)) begin
      vectors++;
      miscompares++;
      $display("FAIL done_wait: got done_e=%0b done_l=%0b expected 1 1", done_e, done_l);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      if (q_e.size() > 0) void'(q_e.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
    end else begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("idle_done", {done_e, done_l}, 0);
      chk("idle_match", match_count_e, 0);
      chk("idle_cycles", cycle_count_e, 0);
      chk("idle_ld_ready", ld_ready_e, 1);
    end
  endtask

  always @(negedge clk) begin
    res_t x;
    if (clear && done_e) begin
      if (q_e.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL sb_e_empty: got done with no expected entry");
      end else begin
        x = q_e.pop_front();
        chk("e_pass", pass_e, x.pass);
        chk("e_code", fail_code_e, x.code);
        chk("e_index", fail_index_e, x.fi);
        chk("e_match", match_count_e, x.mc);
        chk("e_cycles", cycle_count_e, x.cc);
      end
    end
    if (clear && done_l) begin
      if (q_l.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL sb_l_empty: got done with no expected entry");
      end else begin
        x = q_l.pop_front();
        chk("l_pass", pass_l, x.pass);
        chk("l_code", fail_code_l, x.code);
        chk("l_index", fail_index_l, x.fi);
        chk("l_match", match_count_l, x.mc);
        chk("l_cycles", cycle_count_l, x.cc);
      end
    end
  end

  initial begin
    int s, t, len;
    logic [15:0] a, d;
    reset = 1'b0; ld_valid = 1'b0; start = 1'b0; clear = 1'b0; memwrite = 1'b0;
    ld_addr = '0; ld_data = '0; dataaddr = '0; writedata = '0;
    tick(); tick();
    chk("rst_ld_ready", {ld_ready_e, ld_ready_l}, 2'b11);
    chk("rst_done_pass", {done_e, pass_e, done_l, pass_l}, 0);
    chk("rst_code_idx", {fail_code_e, fail_index_e, match_count_e}, 0);
    chk("rst_cycles", cycle_count_e, 0);
    reset = 1'b1;
    tick();

    // start with an empty table must leave the monitor idle
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("empty_start", {ld_ready_e, done_e}, 2'b10);

    n = 1; ea[0] = 16'd80; ed[0] = 16'd12;
    plan_clear(9); plan_store(8, 1, 16'd80, 16'd12);
    run_scn(1'b0, 1'b0);

    plan_clear(4); plan_store(1, 3, 16'd80, 16'd12);
    run_scn(1'b0, 1'b0);

    plan_clear(0);
    run_scn(1'b0, 1'b1);

    n = 2; ea[1] = 16'd84; ed[1] = 16'd7;
    plan_clear(5); plan_store(1, 1, 16'd80, 16'd12); plan_store(3, 1, 16'd84, 16'd9);
    run_scn(1'b0, 1'b0);

    n = 4;
    for (int i = 0; i < 4; i++) begin
      ea[i] = 16'(100 + 4 * i); ed[i] = 16'(i + 1);
    end
    plan_clear(8);
    for (int i = 0; i < 4; i++) plan_store(2 * i, 1, ea[i], ed[i]);
    run_scn(1'b1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        ea[i] = 16'($urandom); ed[i] = 16'($urandom);
      end
      s = n;
      if ($urandom_range(0, 3) == 0) s = ($urandom_range(0, 1) == 1) ? n + 1 : n - 1;
      plan_clear(0);
      t = 0;
      for (int j = 0; j < s; j++) begin
        t += $urandom_range(1, 3);
        len = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 3) : 1;
        a = ea[(j < n) ? j : n - 1];
        d = ed[(j < n) ? j : n - 1];
        if ($urandom_range(0, 7) == 0) a = a ^ 16'h0001;
        else if ($urandom_range(0, 7) == 0) d = d ^ 16'h0004;
        plan_store(t, len, a, d);
        t += len;
      end
      plen = t + 1;
      run_scn($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end

    // reset in the middle of a run, with competing start/load requests
    n = 2; ea[0] = 16'd80; ed[0] = 16'd12; ea[1] = 16'd84; ed[1] = 16'd7;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_addr = ea[i]; ld_data = ed[i];
      tick();
    end
    ld_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; memwrite = 1'b1; dataaddr = 16'd80; writedata = 16'd12;
    tick();
    memwrite = 1'b0;
    tick();
    chk("midrun_match", {match_count_e, match_count_l}, {3'd1, 3'd1});
    chk("midrun_done", done_e, 0);
    reset = 1'b0; start = 1'b1; ld_valid = 1'b1; memwrite = 1'b1; dataaddr = 16'd84; writedata = 16'd7;
    tick();
    reset = 1'b1; start = 1'b0; ld_valid = 1'b0; memwrite = 1'b0;
    chk("midrst_done", {done_e, done_l}, 0);
    chk("midrst_match", {match_count_e, match_count_l}, 0);
    chk("midrst_ld_ready", {ld_ready_e, ld_ready_l}, 2'b11);
    chk("midrst_cycles", cycle_count_e, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
